// File: rtl/fmlarb_pkg.sv
// Shared FML arbiter widths, write burst length and the round-robin next-grant function.
package fmlarb_pkg;

    localparam int FML_AW    = 26;
    localparam int FML_DW    = 64;
    localparam int FML_SW    = 8;
    localparam int FML_BURST = 4;
    localparam int RR_MAX    = 8;

    // Scan from the slot after the current grant; the current holder is visited last.
    function automatic logic [RR_MAX-1:0] rr_next(input logic [RR_MAX-1:0] gnt,
                                                  input logic [RR_MAX-1:0] req,
                                                  input int n);
        logic [RR_MAX-1:0] nxt;
        logic [2:0]        cur;
        logic [2:0]        idx;
        logic              found;
        cur   = '0;
        nxt   = gnt;
        found = 1'b0;
        for (int i = 0; i < RR_MAX; i++)
            if (gnt[i]) cur = 3'(i);
        for (int k = 1; k <= RR_MAX; k++) begin
            if (k <= n && !found) begin
                idx = 3'((int'(cur) + k) % n);
                if (req[idx]) begin
                    nxt      = '0;
                    nxt[idx] = 1'b1;
                    found    = 1'b1;
                end
            end
        end
        return nxt;
    endfunction

endpackage

// File: rtl/fmlarb_rr.sv
// Registered round-robin grant; moves only when told to, holds when nobody requests.
module fmlarb_rr
    import fmlarb_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         sys_clk,
    input  logic         sys_rst_n,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] gnt
);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n)
            gnt <= N'(1);
        else if (advance)
            gnt <= N'(rr_next(RR_MAX'(gnt), RR_MAX'(req), N));
    end

endmodule

// File: rtl/fmlarb_sel.sv
// FML arbiter selector: round-robin grant, request mux, eack steering and
// the write-data phase that follows each acknowledged write.
module fmlarb_sel
    import fmlarb_pkg::*;
#(
    parameter int N     = 4,
    parameter int AW    = FML_AW,
    parameter int DW    = FML_DW,
    parameter int SW    = FML_SW,
    parameter int BURST = FML_BURST
) (
    input  logic            sys_clk,
    input  logic            sys_rst_n,
    input  logic [N-1:0]    m_stb,
    input  logic [N-1:0]    m_we,
    input  logic [N*AW-1:0] m_adr,
    input  logic [N*SW-1:0] m_sel,
    input  logic [N*DW-1:0] m_dw,
    output logic [N-1:0]    m_eack,
    output logic [N-1:0]    m_weack,
    output logic [N-1:0]    m_dwe,
    output logic            s_stb,
    output logic            s_we,
    output logic [AW-1:0]   s_adr,
    input  logic            s_eack,
    output logic [SW-1:0]   s_sel,
    output logic [DW-1:0]   s_dw,
    output logic            err
);

    localparam int CW = $clog2(BURST + 1);

    logic [N-1:0]  gnt;
    logic [N-1:0]  wown;
    logic [CW-1:0] wcnt;
    logic          eack_ev;
    logic          wack_ev;
    logic          advance;
    logic          wact;

    assign s_stb   = |(m_stb & gnt);
    assign eack_ev = s_eack & s_stb;
    assign wack_ev = eack_ev & s_we;
    // A dropped strobe frees the slot just like a completed transaction.
    assign advance = eack_ev | ~s_stb;
    assign m_eack  = gnt & {N{eack_ev}};
    assign m_weack = m_eack & {N{s_we}};
    assign wact    = (wcnt != '0);
    assign m_dwe   = wact ? wown : '0;

    fmlarb_rr #(.N(N)) u_rr (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .req       (m_stb),
        .advance   (advance),
        .gnt       (gnt)
    );

    always_comb begin
        s_we  = 1'b0;
        s_adr = '0;
        s_dw  = '0;
        s_sel = '0;
        for (int i = 0; i < N; i++) begin
            s_we  = s_we | (gnt[i] & m_we[i]);
            s_adr = s_adr | ({AW{gnt[i]}} & m_adr[i*AW +: AW]);
            s_dw  = s_dw  | ({DW{m_dwe[i]}} & m_dw[i*DW +: DW]);
            s_sel = s_sel | ({SW{m_dwe[i]}} & m_sel[i*SW +: SW]);
        end
    end

    // A write eack with more than the final beat outstanding is flagged but still wins.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            wown <= '0;
            wcnt <= '0;
            err  <= 1'b0;
        end else if (wack_ev) begin
            wown <= gnt;
            wcnt <= CW'(BURST);
            err  <= err | (wcnt > CW'(1));
        end else if (wact) begin
            wcnt <= wcnt - CW'(1);
        end
    end

endmodule

// File: tb/tb_fmlarb_sel.sv
// Self-checking bench for fmlarb_sel: table of per-cycle vectors through a scoreboard
// queue, plus hand-written reset sequences.
module tb_fmlarb_sel;
    import fmlarb_pkg::*;

    localparam int N = 4, AW = 26, DW = 64, SW = 8, BURST = 4;

    logic            sys_clk = 1'b0;
    logic            sys_rst_n;
    logic [N-1:0]    m_stb, m_we;
    logic [N*AW-1:0] m_adr;
    logic [N*SW-1:0] m_sel;
    logic [N*DW-1:0] m_dw;
    logic [N-1:0]    m_eack, m_weack, m_dwe;
    logic            s_stb, s_we, s_eack, err;
    logic [AW-1:0]   s_adr;
    logic [SW-1:0]   s_sel;
    logic [DW-1:0]   s_dw;

    fmlarb_sel #(.N(N), .AW(AW), .DW(DW), .SW(SW), .BURST(BURST)) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
        .m_stb(m_stb), .m_we(m_we), .m_adr(m_adr), .m_sel(m_sel), .m_dw(m_dw),
        .m_eack(m_eack), .m_weack(m_weack), .m_dwe(m_dwe),
        .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr), .s_eack(s_eack),
        .s_sel(s_sel), .s_dw(s_dw), .err(err)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        string    name;
        logic [3:0] stb, we;
        logic     eack;
        logic     e_stb;
        int       e_idx;
        logic [3:0] e_eack, e_weack, e_dwe;
        logic     e_err;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic void add(string nm, logic [3:0] stb, logic [3:0] we, logic eack,
                                logic es, int ei, logic [3:0] ee, logic [3:0] ew,
                                logic [3:0] ed, logic er);
        vec_t v;
        v.name = nm; v.stb = stb; v.we = we; v.eack = eack; v.e_stb = es; v.e_idx = ei;
        v.e_eack = ee; v.e_weack = ew; v.e_dwe = ed; v.e_err = er;
        tbl.push_back(v);
    endfunction

    task automatic set_data();
        for (int i = 0; i < N; i++) begin
            m_adr[i*AW +: AW] = AW'(26'h122 + i);
            m_dw[i*DW +: DW]  = {32'(i), 32'(cyc)};
            m_sel[i*SW +: SW] = SW'((i + 1) * 17 + cyc);
        end
    endtask

    function automatic logic [63:0] exp_dw(logic [3:0] d);
        for (int i = 0; i < N; i++) if (d[i]) return m_dw[i*DW +: DW];
        return '0;
    endfunction

    function automatic logic [63:0] exp_sel(logic [3:0] d);
        for (int i = 0; i < N; i++) if (d[i]) return 64'(m_sel[i*SW +: SW]);
        return '0;
    endfunction

    task automatic run_tbl();
        vec_t v;
        foreach (tbl[k]) begin
            @(posedge sys_clk); #1;
            cyc++;
            set_data();
            m_stb  = tbl[k].stb;
            m_we   = tbl[k].we;
            s_eack = tbl[k].eack;
            sb.push_back(tbl[k]);
            @(negedge sys_clk);
            v = sb.pop_front();
            chk({v.name, ".s_stb"},   64'(s_stb),   64'(v.e_stb));
            chk({v.name, ".s_adr"},   64'(s_adr),   64'(AW'(26'h122 + v.e_idx)));
            chk({v.name, ".m_eack"},  64'(m_eack),  64'(v.e_eack));
            chk({v.name, ".m_weack"}, 64'(m_weack), 64'(v.e_weack));
            chk({v.name, ".m_dwe"},   64'(m_dwe),   64'(v.e_dwe));
            chk({v.name, ".s_dw"},    64'(s_dw),    exp_dw(v.e_dwe));
            chk({v.name, ".s_sel"},   64'(s_sel),   exp_sel(v.e_dwe));
            chk({v.name, ".err"},     64'(err),     64'(v.e_err));
        end
        tbl.delete();
    endtask

    initial begin
        sys_rst_n = 1'b0;
        m_stb = 4'b0010; m_we = '0; s_eack = 1'b0;
        set_data();
        repeat (2) @(negedge sys_clk);
        chk("rst.s_stb", 64'(s_stb), 64'(0));
        chk("rst.s_adr", 64'(s_adr), 64'(26'h122));
        chk("rst.m_dwe", 64'(m_dwe), 64'(0));
        chk("rst.err",   64'(err),   64'(0));
        sys_rst_n = 1'b1;
        @(negedge sys_clk);
        chk("rel.s_adr", 64'(s_adr), 64'(26'h123));
        chk("rel.s_stb", 64'(s_stb), 64'(1));

        // reads from masters 0 and 2, eack every third cycle
        add("rd0", 4'b0101, 4'b0000, 0, 0, 1, 4'b0000, 4'b0000, 4'b0000, 0);
        add("rd1", 4'b0101, 4'b0000, 0, 1, 2, 4'b0000, 4'b0000, 4'b0000, 0);
        add("rd2", 4'b0101, 4'b0000, 0, 1, 2, 4'b0000, 4'b0000, 4'b0000, 0);
        add("rd3", 4'b0101, 4'b0000, 1, 1, 2, 4'b0100, 4'b0000, 4'b0000, 0);
        add("rd4", 4'b0101, 4'b0000, 0, 1, 0, 4'b0000, 4'b0000, 4'b0000, 0);
        add("rd5", 4'b0101, 4'b0000, 0, 1, 0, 4'b0000, 4'b0000, 4'b0000, 0);
        add("rd6", 4'b0101, 4'b0000, 1, 1, 0, 4'b0001, 4'b0000, 4'b0000, 0);
        add("rd7", 4'b0101, 4'b0000, 0, 1, 2, 4'b0000, 4'b0000, 4'b0000, 0);
        add("rd8", 4'b0101, 4'b0000, 0, 1, 2, 4'b0000, 4'b0000, 4'b0000, 0);
        add("rd9", 4'b0101, 4'b0000, 1, 1, 2, 4'b0100, 4'b0000, 4'b0000, 0);
        add("rdA", 4'b0101, 4'b0000, 0, 1, 0, 4'b0000, 4'b0000, 4'b0000, 0);
        // single write from master 1 at 0x123
        add("wr0", 4'b0010, 4'b0010, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 0);
        add("wrT", 4'b0010, 4'b0010, 1, 1, 1, 4'b0010, 4'b0010, 4'b0000, 0);
        for (int b = 1; b <= 4; b++)
            add($sformatf("wrB%0d", b), 4'b0000, 4'b0000, 0, 0, 1, 4'b0000, 4'b0000, 4'b0010, 0);
        add("wrE", 4'b0000, 4'b0000, 0, 0, 1, 4'b0000, 4'b0000, 4'b0000, 0);
        // back-to-back: master 0 write, master 3 write on the last beat
        add("bb0", 4'b0001, 4'b0001, 0, 0, 1, 4'b0000, 4'b0000, 4'b0000, 0);
        add("bbT", 4'b1001, 4'b1001, 1, 1, 0, 4'b0001, 4'b0001, 4'b0000, 0);
        for (int b = 1; b <= 3; b++)
            add($sformatf("bbA%0d", b), 4'b1000, 4'b1000, 0, 1, 3, 4'b0000, 4'b0000, 4'b0001, 0);
        add("bbA4", 4'b1000, 4'b1000, 1, 1, 3, 4'b1000, 4'b1000, 4'b0001, 0);
        for (int b = 5; b <= 8; b++)
            add($sformatf("bbB%0d", b), 4'b0000, 4'b0000, 0, 0, 3, 4'b0000, 4'b0000, 4'b1000, 0);
        add("bbE", 4'b0000, 4'b0000, 0, 0, 3, 4'b0000, 4'b0000, 4'b0000, 0);
        // premature second write eack sets sticky err
        add("er0", 4'b0100, 4'b0100, 0, 0, 3, 4'b0000, 4'b0000, 4'b0000, 0);
        add("erT", 4'b0110, 4'b0110, 1, 1, 2, 4'b0100, 4'b0100, 4'b0000, 0);
        add("er1", 4'b0010, 4'b0010, 0, 1, 1, 4'b0000, 4'b0000, 4'b0100, 0);
        add("er2", 4'b0010, 4'b0010, 1, 1, 1, 4'b0010, 4'b0010, 4'b0100, 0);
        for (int b = 3; b <= 6; b++)
            add($sformatf("er%0d", b), 4'b0000, 4'b0000, 0, 0, 1, 4'b0000, 4'b0000, 4'b0010, 1);
        add("er7", 4'b0000, 4'b0000, 0, 0, 1, 4'b0000, 4'b0000, 4'b0000, 1);
        // granted master drops strobe; eack while not strobing must not pulse
        add("dr0", 4'b0010, 4'b0000, 0, 1, 1, 4'b0000, 4'b0000, 4'b0000, 1);
        add("dr1", 4'b1000, 4'b0000, 1, 0, 1, 4'b0000, 4'b0000, 4'b0000, 1);
        add("dr2", 4'b1000, 4'b0000, 0, 1, 3, 4'b0000, 4'b0000, 4'b0000, 1);
        run_tbl();

        // reset asserted mid-burst aborts the write phase immediately
        @(posedge sys_clk); #1;
        m_stb = 4'b1000; m_we = 4'b1000; s_eack = 1'b1;
        @(posedge sys_clk); #1;
        m_stb = '0; m_we = '0; s_eack = 1'b0;
        @(negedge sys_clk);
        chk("ar.dwe_before", 64'(m_dwe), 64'(4'b1000));
        #2 sys_rst_n = 1'b0;
        #1;
        chk("ar.dwe_async", 64'(m_dwe), 64'(0));
        chk("ar.err_clr",   64'(err),   64'(0));
        chk("ar.s_adr",     64'(s_adr), 64'(26'h122));
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        @(negedge sys_clk);
        chk("ar.dwe_after", 64'(m_dwe), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
